vec_lane_alu: RTL
=================

# vec_lane_alu

Multi-lane, beat-serialised vector integer ALU. It executes one RVV arithmetic/logic instruction over a full VLEN-bit register group. Each beat processes NB_LANES×LANE_W bits, and carries and borrows are chained across lane and beat boundaries for elements wider than a lane. It sits between the vector register-file read port and the write-back buffer, and generalises the single-lane ALU with subtraction, reverse subtraction, ready/valid back-pressure, an error path and optional masking.

## Interface
- VLEN, 128: vector register width in bits; multiple of BEAT_W = NB_LANES×LANE_W.
- LANE_W, 16: lane width in bits; one of 8, 16, 32, 64.
- NB_LANES, 2: lanes per beat; power of two, 1–8.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  request; accepted only when busy=0.
- opcode  in  6  000000 vadd, 000010 vsub, 000011 vrsub, 001001 vand, 001010 vor, 001011 vxor.
- op_type  in  3  001 VV, 010 VX, 100 VI.
- vsew  in  3  SEW = 8<<vsew; only 0–3 are legal.
- vs1  in  VLEN  first operand vector (VV).
- vs2  in  VLEN  second operand vector.
- xs  in  64  scalar operand (VX), truncated to SEW.
- imm  in  5  immediate (VI), sign-extended to SEW.
- busy  out  1  instruction in flight.
- out_valid  out  1  beat present.
- out_ready  in  1  consumer accepts beat.
- out_data  out  BEAT_W  result beat.
- out_idx  out  $clog2(VLEN/BEAT_W)  beat number.
- out_be  out  BEAT_W/8  byte write enables.
- done  out  1  one-cycle pulse when the instruction ends.
- err  out  1  one-cycle pulse with done for an illegal vsew or opcode.

## Operation
- Operands vs1, vs2, opcode, op_type, vsew, xs and imm are latched on an accepted start. Inputs may change afterwards.
- In VX and VI modes the scalar is replicated per SEW element across the beat.
- Logic ops are bitwise.
- vadd computes vs2+op1. vsub computes vs2−op1. vrsub computes op1−vs2.
  - Subtraction is implemented as an add of the inverted operand with carry-in 1, applied at each element start.
- Carry chain: each LANE_W chunk adds with a carry-in.
  - The carry-in is the initial value (0 for add, 1 for sub) when the chunk's bit offset mod SEW = 0.
  - Otherwise it is the carry-out of the previous chunk.
  - Chunk 0 of a beat takes the carry from the `carry_q` register.
- When SEW < LANE_W, the carry is also broken inside the lane at every SEW boundary.
- FSM states:
  - IDLE: on start, go to RUN, or to ERR if vsew>3 or the opcode is unsupported.
  - RUN: emit beats 0..VLEN/BEAT_W−1. After the last beat is accepted, go to DONE.
  - DONE: pulse done, then go to IDLE.
  - ERR: pulse done and err, then go to IDLE. No beats are emitted.
- `carry_q` and the beat counter advance only on out_valid & out_ready.
- out_be is all ones unless masking is compiled in (see Configuration).

## Timing
- Reset value of every output is 0: busy, out_valid, out_data, out_idx, out_be, done, err. FSM resets to IDLE and `carry_q` to 0.
- busy rises the cycle after start is accepted and falls in the cycle done is high.
- Beat 0 appears with out_valid high 1 cycle after start acceptance, from a registered output stage.
- Throughput is 1 beat per cycle while out_ready=1. N beats give done at cycle N+1 after acceptance.
- While out_valid=1 & out_ready=0, out_data, out_idx and out_be hold stable.
- out_valid never drops without acceptance.
- ERR path: done and err pulse at cycle 1 after acceptance.
- start while busy=1 is ignored. start in the DONE cycle is ignored.
- resetn low mid-instruction aborts it. All outputs are 0 on the next edge and there is no done pulse.

## Configuration
- VLANE_MASK_EN defined:
  - Adds input vm (1 bit) and input v0 (VLEN bits).
  - When vm=0, the bytes of element i have out_be cleared when v0[i]=0. The mask is latched at start.
  - Data is still computed for masked elements.
- VLANE_MASK_EN undefined: the vm and v0 ports are absent and out_be is all ones.

## Structure
- Shared package vlane_pkg holds:
  - opcode and op_type localparams;
  - the FSM state enum;
  - a function computing the SEW bit width from vsew.
- One sub-module, vlane_chunk_add: a LANE_W-bit adder with per-SEW carry break. It is instantiated NB_LANES times, with logic ops muxed at its output.

## Test plan
All scenarios use VLEN=128, LANE_W=16, NB_LANES=2, so BEAT_W=32 and there are 4 beats.
- vadd.vv, SEW=64, vs1 = {64'h1, 64'hFFFF_FFFF_FFFF_FFFF}, vs2 = {64'h0, 64'h1} -> beats 0–3 = 0, 0, 1, 0. Carry crosses beat 0→1; element 1 gets no carry from element 0.
- vsub.vx, SEW=8, vs2=0, xs=1 -> every beat 32'hFFFF_FFFF; no borrow between bytes.
- vrsub.vi, SEW=16, imm=5'b11111 (−1), vs2 halfwords=1 -> every halfword 16'hFFFE.
- out_ready low for 3 cycles at beat 2 -> out_idx=2 and out_data stable; exactly 4 accepted beats; done 1 cycle after the last acceptance.
- vsew=3'b100 -> done=err=1 at cycle 1, out_valid never asserted, busy low afterwards.
- resetn low at beat 1 -> all outputs 0 next cycle; a fresh vand.vv then completes correctly (vs1 & vs2 checked per beat). With VLANE_MASK_EN, SEW=32, vm=0, v0=4'b0101 -> out_be = 4'hF, 0, F, 0 per beat.

Source files
------------

// File: rtl/vlane_pkg.sv
// vlane_pkg: opcodes, operand-type codes, FSM states and the SEW helper
// shared by the vector lane ALU files.
package vlane_pkg;

  localparam logic [5:0] OP_VADD  = 6'b000000;
  localparam logic [5:0] OP_VSUB  = 6'b000010;
  localparam logic [5:0] OP_VRSUB = 6'b000011;
  localparam logic [5:0] OP_VAND  = 6'b001001;
  localparam logic [5:0] OP_VOR   = 6'b001010;
  localparam logic [5:0] OP_VXOR  = 6'b001011;

  localparam logic [2:0] OPT_VV = 3'b001;
  localparam logic [2:0] OPT_VX = 3'b010;
  localparam logic [2:0] OPT_VI = 3'b100;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERR} state_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [2:0]  op_type;
    logic [2:0]  vsew;
    logic [63:0] xs;
    logic [4:0]  imm;
  } instr_t;

  function automatic logic [6:0] sew_bits(input logic [2:0] vsew);
    return 7'd8 << vsew[1:0];
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_VADD, OP_VSUB, OP_VRSUB, OP_VAND, OP_VOR, OP_VXOR};
  endfunction

endpackage

// File: rtl/vec_lane_alu_chunk.sv
// vlane_chunk_add: LANE_W-bit adder whose carry is re-seeded at every SEW
// element boundary, so narrow elements inside one lane stay independent.
module vlane_chunk_add #(
  parameter int LANE_W = 16
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              cin,
  input  logic              cinit,
  input  logic              chunk_start,
  input  logic [6:0]        sew,
  output logic [LANE_W-1:0] sum,
  output logic              cout
);

  localparam int NBYTES = LANE_W / 8;

  logic carry;

  // SEW is at least 8, so element boundaries can only fall on byte edges.
  always_comb begin
    sum   = '0;
    carry = chunk_start ? cinit : cin;
    for (int k = 0; k < NBYTES; k++) begin
      if (k != 0 && ((k * 8) & (int'(sew) - 1)) == 0) carry = cinit;
      {carry, sum[k*8 +: 8]} = {1'b0, a[k*8 +: 8]} + {1'b0, b[k*8 +: 8]} + {8'b0, carry};
    end
    cout = carry;
  end

endmodule

// File: rtl/vec_lane_alu.sv
// vec_lane_alu: beat-serialised multi-lane vector integer ALU (vadd/vsub/vrsub/vand/vor/vxor).
// Define VLANE_MASK_EN to add the vm/v0 ports that clear byte enables of inactive elements.
module vec_lane_alu
  import vlane_pkg::*;
#(
  parameter int VLEN     = 128,
  parameter int LANE_W   = 16,
  parameter int NB_LANES = 2,
  localparam int BEAT_W  = NB_LANES * LANE_W,
  localparam int NBEATS  = VLEN / BEAT_W,
  localparam int IDX_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [5:0]          opcode,
  input  logic [2:0]          op_type,
  input  logic [2:0]          vsew,
  input  logic [VLEN-1:0]     vs1,
  input  logic [VLEN-1:0]     vs2,
  input  logic [63:0]         xs,
  input  logic [4:0]          imm,
`ifdef VLANE_MASK_EN
  input  logic                vm,
  input  logic [VLEN-1:0]     v0,
`endif
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BEAT_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic [BEAT_W/8-1:0] out_be,
  output logic                done,
  output logic                err
);

  state_e               state_q, state_d;
  instr_t               ins_q, ins_d, ins_in, ins_s;
  logic [VLEN-1:0]      vs1_q, vs1_d, vs2_q, vs2_d, vs1_s, vs2_s;
  logic                 busy_q, busy_d, out_valid_q, out_valid_d;
  logic                 done_q, done_d, err_q, err_d, carry_q, carry_d;
  logic [BEAT_W-1:0]    out_data_q, out_data_d;
  logic [IDX_W-1:0]     out_idx_q, out_idx_d;
  logic [BEAT_W/8-1:0]  out_be_q, out_be_d;
`ifdef VLANE_MASK_EN
  logic                 vm_q, vm_d, vm_s;
  logic [VLEN-1:0]      v0_q, v0_d, v0_s;
`endif

  logic                 idle;
  logic [IDX_W-1:0]     beat_s;
  int                   beat_off;
  logic [6:0]           sew;
  logic [5:0]           sew_m;
  logic [63:0]          scalar;
  logic [VLEN-1:0]      rep_vec, op1_vec;
  logic [BEAT_W-1:0]    op1_beat, vs2_beat, add_a, add_b, beat_data;
  logic [BEAT_W/8-1:0]  beat_be;
  logic                 cinit;
  logic [NB_LANES:0]    chain;

  // While idle the beat datapath looks at the live inputs, so beat 0 can be
  // registered on the very edge that accepts start.
  always_comb begin
    ins_in.opcode  = opcode;
    ins_in.op_type = op_type;
    ins_in.vsew    = vsew;
    ins_in.xs      = xs;
    ins_in.imm     = imm;
  end

  assign idle     = (state_q == ST_IDLE);
  assign ins_s    = idle ? ins_in : ins_q;
  assign vs1_s    = idle ? vs1 : vs1_q;
  assign vs2_s    = idle ? vs2 : vs2_q;
  assign beat_s   = idle ? '0 : out_idx_q + 1'b1;
  assign beat_off = int'(beat_s) * BEAT_W;
  assign sew      = sew_bits(ins_s.vsew);
  assign sew_m    = 6'(sew - 7'd1);

  always_comb begin
    scalar  = (ins_s.op_type == OPT_VI) ? {{59{ins_s.imm[4]}}, ins_s.imm} : ins_s.xs;
    rep_vec = '0;
    for (int i = 0; i < VLEN; i++) rep_vec[i] = scalar[6'(i) & sew_m];
    op1_vec = (ins_s.op_type == OPT_VX || ins_s.op_type == OPT_VI) ? rep_vec : vs1_s;
  end

  assign op1_beat = op1_vec[beat_off +: BEAT_W];
  assign vs2_beat = vs2_s[beat_off +: BEAT_W];

  // Subtractions become an add of the inverted operand, seeded with 1 per element.
  always_comb begin
    add_a = vs2_beat;
    add_b = op1_beat;
    cinit = 1'b0;
    case (ins_s.opcode)
      OP_VSUB: begin
        add_b = ~op1_beat;
        cinit = 1'b1;
      end
      OP_VRSUB: begin
        add_a = op1_beat;
        add_b = ~vs2_beat;
        cinit = 1'b1;
      end
      default: ;
    endcase
  end

  assign chain[0] = carry_q;

  for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
    logic              lane_start;
    logic [LANE_W-1:0] lane_sum, a_l, b_l;

    assign lane_start = (((beat_off + l * LANE_W) & (int'(sew) - 1)) == 0);
    assign a_l        = vs2_beat[l*LANE_W +: LANE_W];
    assign b_l        = op1_beat[l*LANE_W +: LANE_W];

    vlane_chunk_add #(.LANE_W(LANE_W)) u_add (
      .a           (add_a[l*LANE_W +: LANE_W]),
      .b           (add_b[l*LANE_W +: LANE_W]),
      .cin         (chain[l]),
      .cinit       (cinit),
      .chunk_start (lane_start),
      .sew         (sew),
      .sum         (lane_sum),
      .cout        (chain[l+1])
    );

    assign beat_data[l*LANE_W +: LANE_W] =
      (ins_s.opcode == OP_VAND) ? (a_l & b_l) :
      (ins_s.opcode == OP_VOR)  ? (a_l | b_l) :
      (ins_s.opcode == OP_VXOR) ? (a_l ^ b_l) : lane_sum;
  end

`ifdef VLANE_MASK_EN
  assign vm_s = idle ? vm : vm_q;
  assign v0_s = idle ? v0 : v0_q;

  always_comb begin
    beat_be = '0;
    for (int j = 0; j < BEAT_W / 8; j++) begin
      beat_be[j] = vm_s | v0_s[(beat_off + j * 8) >> (int'(ins_s.vsew[1:0]) + 3)];
    end
  end
`else
  assign beat_be = '1;
`endif

  always_comb begin
    state_d     = state_q;
    ins_d       = ins_q;
    vs1_d       = vs1_q;
    vs2_d       = vs2_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_be_d    = out_be_q;
    carry_d     = carry_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef VLANE_MASK_EN
    vm_d        = vm_q;
    v0_d        = v0_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ins_d = ins_in;
          vs1_d = vs1;
          vs2_d = vs2;
`ifdef VLANE_MASK_EN
          vm_d  = vm;
          v0_d  = v0;
`endif
          if (ins_in.vsew[2] || !op_legal(ins_in.opcode)) begin
            state_d = ST_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = ST_RUN;
            busy_d      = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = beat_data;
            out_be_d    = beat_be;
            out_idx_d   = beat_s;
            carry_d     = chain[NB_LANES];
          end
        end
      end
      ST_RUN: begin
        if (out_valid_q && out_ready) begin
          if (out_idx_q == IDX_W'(NBEATS - 1)) begin
            state_d     = ST_DONE;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_be_d    = '0;
            out_idx_d   = '0;
            carry_d     = 1'b0;
            done_d      = 1'b1;
          end else begin
            out_data_d = beat_data;
            out_be_d   = beat_be;
            out_idx_d  = beat_s;
            carry_d    = chain[NB_LANES];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ins_q       <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_be_q    <= '0;
      carry_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef VLANE_MASK_EN
      vm_q        <= 1'b0;
      v0_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ins_q       <= ins_d;
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_be_q    <= out_be_d;
      carry_q     <= carry_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef VLANE_MASK_EN
      vm_q        <= vm_d;
      v0_q        <= v0_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_be    = out_be_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
